axi_lite_uart_regs: RTL and testbench

- AXI4-Lite responder implementing the UART Lite register map: RX FIFO 0x0, TX FIFO 0x4, STAT 0x8, CTRL 0xC.
- Buffers bytes in TX and RX FIFOs.
- Exposes byte-stream handshakes to a separate bit-level serializer/deserializer.
- Raises an interrupt pulse on TX-drain and RX-arrival events.
- Sits in the slot our bench drives as the AXI initiator.

---
 rtl/uart_lite_pkg.sv | 32 +++
 rtl/axi_lite_uart_regs_if.sv | 34 +++
 rtl/sync_fifo.sv | 46 ++++
 rtl/axi_lite_uart_regs.sv | 174 +++++++++++++++++
 tb/tb_axi_lite_uart_regs.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_lite_pkg.sv
// rtl/uart_lite_pkg.sv - register map, bit indices and FSM states for the UART Lite register block
package uart_lite_pkg;

    localparam logic [3:0] ADDR_RX   = 4'h0;
    localparam logic [3:0] ADDR_TX   = 4'h4;
    localparam logic [3:0] ADDR_STAT = 4'h8;
    localparam logic [3:0] ADDR_CTRL = 4'hC;

    localparam int STAT_RX_VALID   = 0;
    localparam int STAT_RX_FULL    = 1;
    localparam int STAT_TX_EMPTY   = 2;
    localparam int STAT_TX_FULL    = 3;
    localparam int STAT_INTR_EN    = 4;
    localparam int STAT_OVERRUN    = 5;
    localparam int STAT_FRAME_ERR  = 6;
    localparam int STAT_PARITY_ERR = 7;

    localparam int CTRL_RST_TX  = 0;
    localparam int CTRL_RST_RX  = 1;
    localparam int CTRL_INTR_EN = 4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Word-aligned register match; the byte-lane bits of the address are don't-care.
    function automatic logic addr_is(input logic [3:0] addr, input logic [3:0] reg_off);
        return addr[3:2] == reg_off[3:2];
    endfunction

endpackage

// File: rtl/axi_lite_uart_regs_if.sv
// rtl/axi_lite_uart_regs_if.sv - AXI4-Lite bus bundle for the UART Lite register block
interface axi_lite_uart_regs_if;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers, synchronous clear, push-through when full and popping
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A slot freed by a same-cycle pop can take the incoming word even at full.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear wins over any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/axi_lite_uart_regs.sv
// rtl/axi_lite_uart_regs.sv - AXI4-Lite UART Lite register block with TX/RX FIFOs and event interrupt
module axi_lite_uart_regs
    import uart_lite_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_areset,
    output logic                 interrupt,
    axi_lite_uart_regs_if.slave  s_axi,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_frame_err,
    input  logic                 rx_parity_err
);
    wr_state_t             w_state;
    rd_state_t             r_state;
    logic                  wr_fire, rd_fire;
    logic                  wr_tx, wr_ctrl, rd_rx, rd_stat;
    logic                  tx_clr, rx_clr, tx_full, tx_empty, rx_full, rx_empty;
    logic                  rx_pop_eff, overrun_set;
    logic [DATA_BITS-1:0]  rx_head;
    logic                  intr_en, overrun, frame_err, parity_err;
    logic                  tx_empty_q, rx_ne_q;
    logic [7:0]            stat_bits;
    logic [31:0]           rdata_next;
    logic                  unused_bits;

    assign unused_bits = ^{s_axi.s_axi_wstrb, s_axi.s_axi_wdata, s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

    assign wr_fire = s_axi.s_axi_awready && s_axi.s_axi_awvalid && s_axi.s_axi_wvalid;
    assign rd_fire = s_axi.s_axi_arready && s_axi.s_axi_arvalid;
    assign wr_tx   = wr_fire && addr_is(s_axi.s_axi_awaddr, ADDR_TX);
    assign wr_ctrl = wr_fire && addr_is(s_axi.s_axi_awaddr, ADDR_CTRL);
    assign rd_rx   = rd_fire && addr_is(s_axi.s_axi_araddr, ADDR_RX);
    assign rd_stat = rd_fire && addr_is(s_axi.s_axi_araddr, ADDR_STAT);
    assign tx_clr  = wr_ctrl && s_axi.s_axi_wdata[CTRL_RST_TX];
    assign rx_clr  = wr_ctrl && s_axi.s_axi_wdata[CTRL_RST_RX];

    // A byte arriving at full is only lost if the host is not popping in the same cycle.
    assign rx_pop_eff  = rd_rx && !rx_empty;
    assign overrun_set = rx_valid && rx_full && !rx_pop_eff;

    assign tx_valid           = !tx_empty;
    assign s_axi.s_axi_bresp  = RESP_OKAY;
    assign s_axi.s_axi_rresp  = RESP_OKAY;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(s_axi_aclk), .rst(s_axi_areset), .push(wr_tx), .pop(tx_valid && tx_ready),
        .clr(tx_clr), .din(s_axi.s_axi_wdata[DATA_BITS-1:0]), .dout(tx_data),
        .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(s_axi_aclk), .rst(s_axi_areset), .push(rx_valid), .pop(rd_rx),
        .clr(rx_clr), .din(rx_data), .dout(rx_head),
        .full(rx_full), .empty(rx_empty)
    );

    assign stat_bits[STAT_RX_VALID]   = !rx_empty;
    assign stat_bits[STAT_RX_FULL]    = rx_full;
    assign stat_bits[STAT_TX_EMPTY]   = tx_empty;
    assign stat_bits[STAT_TX_FULL]    = tx_full;
    assign stat_bits[STAT_INTR_EN]    = intr_en;
    assign stat_bits[STAT_OVERRUN]    = overrun;
    assign stat_bits[STAT_FRAME_ERR]  = frame_err;
    assign stat_bits[STAT_PARITY_ERR] = parity_err;

    // Read data selected from the current address; captured only on the AR handshake.
    always_comb begin
        rdata_next = '0;
        if (addr_is(s_axi.s_axi_araddr, ADDR_RX)) begin
            if (!rx_empty) rdata_next = 32'(rx_head);
        end else if (addr_is(s_axi.s_axi_araddr, ADDR_STAT)) begin
            rdata_next = {24'h0, stat_bits};
        end
    end

    // Write FSM: one-cycle ready pulse once both address and data are present, then hold the response.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state             <= W_IDLE;
            s_axi.s_axi_awready <= 1'b0;
            s_axi.s_axi_wready  <= 1'b0;
            s_axi.s_axi_bvalid  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_fire) begin
                        s_axi.s_axi_awready <= 1'b0;
                        s_axi.s_axi_wready  <= 1'b0;
                        s_axi.s_axi_bvalid  <= 1'b1;
                        w_state             <= W_RESP;
                    end else if (s_axi.s_axi_awvalid && s_axi.s_axi_wvalid && !s_axi.s_axi_awready) begin
                        s_axi.s_axi_awready <= 1'b1;
                        s_axi.s_axi_wready  <= 1'b1;
                    end else begin
                        s_axi.s_axi_awready <= 1'b0;
                        s_axi.s_axi_wready  <= 1'b0;
                    end
                end
                W_RESP: begin
                    if (s_axi.s_axi_bready) begin
                        s_axi.s_axi_bvalid <= 1'b0;
                        w_state            <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: pulse arready, register the data on the handshake, hold it until rready.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state             <= R_IDLE;
            s_axi.s_axi_arready <= 1'b0;
            s_axi.s_axi_rvalid  <= 1'b0;
            s_axi.s_axi_rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_fire) begin
                        s_axi.s_axi_arready <= 1'b0;
                        s_axi.s_axi_rdata   <= rdata_next;
                        s_axi.s_axi_rvalid  <= 1'b1;
                        r_state             <= R_DATA;
                    end else begin
                        s_axi.s_axi_arready <= s_axi.s_axi_arvalid && !s_axi.s_axi_arready;
                    end
                end
                R_DATA: begin
                    if (s_axi.s_axi_rready) begin
                        s_axi.s_axi_rvalid <= 1'b0;
                        r_state            <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Control latch and sticky error flags; a new error in the clearing read cycle survives.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            intr_en    <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (wr_ctrl) intr_en <= s_axi.s_axi_wdata[CTRL_INTR_EN];
            overrun    <= (overrun && !rd_stat) || overrun_set;
            frame_err  <= (frame_err && !rd_stat) || (rx_valid && rx_frame_err);
            parity_err <= (parity_err && !rd_stat) || (rx_valid && rx_parity_err);
        end
    end

    // Interrupt pulse on TX-empty or RX-not-empty rising edges; enabling alone never fires.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            tx_empty_q <= 1'b1;
            rx_ne_q    <= 1'b0;
            interrupt  <= 1'b0;
        end else begin
            tx_empty_q <= tx_empty;
            rx_ne_q    <= !rx_empty;
            interrupt  <= intr_en && ((tx_empty && !tx_empty_q) || (!rx_empty && !rx_ne_q));
        end
    end
endmodule

// File: tb/tb_axi_lite_uart_regs.sv
// tb/tb_axi_lite_uart_regs.sv - self-checking bench for axi_lite_uart_regs
module tb_axi_lite_uart_regs;
    import uart_lite_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       interrupt;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h0;
    logic       rx_valid = 1'b0;
    logic       rx_fe = 1'b0;
    logic       rx_pe = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_lite_uart_regs_if bus ();

    axi_lite_uart_regs #(.FIFO_DEPTH(DEPTH), .DATA_BITS(8)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .interrupt    (interrupt),
        .s_axi        (bus.slave),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_fe),
        .rx_parity_err(rx_pe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queues for the FIFOs, flags for STAT, updated from observed bus handshakes.
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic        m_intr_en, m_ovr, m_fe, m_pe, m_prev_txe, m_prev_rxne, exp_intr;
    logic [31:0] exp_rdata, m_stat;
    logic        m_wr, m_rd, m_tx_full, m_rx_full, m_rx_pop, m_tx_pop, m_stat_rd, m_ovr_set;
    logic [1:0]  m_wsel, m_rsel;

    always @(negedge clk) begin
        if (rst) begin
            txq.delete(); rxq.delete();
            m_intr_en = 0; m_ovr = 0; m_fe = 0; m_pe = 0;
            m_prev_txe = 1; m_prev_rxne = 0; exp_intr = 0; exp_rdata = 0;
        end else begin
            chk("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
            if (txq.size() != 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
            chk("interrupt", 32'(interrupt), 32'(exp_intr));
            if (bus.s_axi_rvalid) chk("rdata", bus.s_axi_rdata, exp_rdata);

            exp_intr    = m_intr_en && ((txq.size() == 0 && !m_prev_txe) || (rxq.size() != 0 && !m_prev_rxne));
            m_prev_txe  = txq.size() == 0;
            m_prev_rxne = rxq.size() != 0;

            m_wr      = bus.s_axi_awvalid && bus.s_axi_awready && bus.s_axi_wvalid && bus.s_axi_wready;
            m_rd      = bus.s_axi_arvalid && bus.s_axi_arready;
            m_wsel    = bus.s_axi_awaddr[3:2];
            m_rsel    = bus.s_axi_araddr[3:2];
            m_tx_full = txq.size() == DEPTH;
            m_rx_full = rxq.size() == DEPTH;
            m_stat    = {24'h0, m_pe, m_fe, m_ovr, m_intr_en, m_tx_full, txq.size() == 0, m_rx_full, rxq.size() != 0};
            m_rx_pop  = m_rd && m_rsel == 2'd0 && rxq.size() != 0;
            m_stat_rd = m_rd && m_rsel == 2'd2;
            if (m_rd) exp_rdata = m_stat_rd ? m_stat : (m_rx_pop ? {24'h0, rxq[0]} : 32'h0);
            m_tx_pop  = tx_ready && txq.size() != 0;
            m_ovr_set = rx_valid && m_rx_full && !m_rx_pop;

            if (m_wr && m_wsel == 2'd3 && bus.s_axi_wdata[0]) txq.delete();
            else begin
                if (m_tx_pop) void'(txq.pop_front());
                if (m_wr && m_wsel == 2'd1 && (!m_tx_full || m_tx_pop)) txq.push_back(bus.s_axi_wdata[7:0]);
            end
            if (m_wr && m_wsel == 2'd3 && bus.s_axi_wdata[1]) rxq.delete();
            else begin
                if (m_rx_pop) void'(rxq.pop_front());
                if (rx_valid && (!m_rx_full || m_rx_pop)) rxq.push_back(rx_data);
            end
            m_ovr = (m_ovr && !m_stat_rd) || m_ovr_set;
            m_fe  = (m_fe && !m_stat_rd) || (rx_valid && rx_fe);
            m_pe  = (m_pe && !m_stat_rd) || (rx_valid && rx_pe);
            if (m_wr && m_wsel == 2'd3) m_intr_en = bus.s_axi_wdata[4];
        end
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb, input int hold);
        int  cyc;
        logic ok;
        @(posedge clk); #1;
        bus.s_axi_awaddr = addr; bus.s_axi_wdata = data; bus.s_axi_wstrb = strb;
        bus.s_axi_awvalid = 1; bus.s_axi_wvalid = 1; bus.s_axi_bready = 0;
        cyc = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.s_axi_awready && bus.s_axi_wready) begin ok = 1; break; end
            cyc++;
        end
        chk("write accepted", 32'(ok), 32'd1);
        chk("wready latency", 32'(cyc), 32'd1);
        @(posedge clk); #1;
        bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.s_axi_bvalid) begin ok = 1; break; end
        end
        chk("bvalid", 32'(ok), 32'd1);
        chk("bresp", 32'(bus.s_axi_bresp), 32'd0);
        if (hold > 0) begin
            @(posedge clk); #1;
            bus.s_axi_awaddr = ADDR_STAT; bus.s_axi_awvalid = 1; bus.s_axi_wvalid = 1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("bvalid held", 32'(bus.s_axi_bvalid), 32'd1);
                chk("second write blocked", 32'(bus.s_axi_awready | bus.s_axi_wready), 32'd0);
            end
        end
        @(posedge clk); #1;
        bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0; bus.s_axi_bready = 1;
        @(posedge clk); #1;
        bus.s_axi_bready = 0;
        @(negedge clk);
        chk("bvalid cleared", 32'(bus.s_axi_bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        logic ok;
        @(posedge clk); #1;
        bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1; bus.s_axi_rready = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.s_axi_arready) begin ok = 1; break; end
        end
        chk("read accepted", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.s_axi_arvalid = 0; bus.s_axi_rready = 1;
        @(negedge clk);
        chk("rvalid latency", 32'(bus.s_axi_rvalid), 32'd1);
        chk("rresp", 32'(bus.s_axi_rresp), 32'd0);
        data = bus.s_axi_rdata;
        @(posedge clk); #1;
        bus.s_axi_rready = 0;
        @(negedge clk);
        chk("rvalid cleared", 32'(bus.s_axi_rvalid), 32'd0);
    endtask

    task automatic rx_push(input logic [7:0] d, input logic fe, input logic pe);
        @(posedge clk); #1;
        rx_data = d; rx_valid = 1; rx_fe = fe; rx_pe = pe;
        @(posedge clk); #1;
        rx_valid = 0; rx_fe = 0; rx_pe = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int pulses, got;
        bus.s_axi_awaddr = 0; bus.s_axi_awvalid = 0; bus.s_axi_wdata = 0; bus.s_axi_wstrb = 0;
        bus.s_axi_wvalid = 0; bus.s_axi_bready = 0; bus.s_axi_araddr = 0; bus.s_axi_arvalid = 0;
        bus.s_axi_rready = 0;

        repeat (5) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset valids", 32'({tx_valid, bus.s_axi_bvalid, bus.s_axi_rvalid, interrupt}), 32'd0);
        chk("reset readies", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 32'd0);
        axi_read(ADDR_STAT, d);
        chk("reset STAT", d, 32'h04);

        axi_write(ADDR_CTRL, 32'h13, 4'h2, 0);
        axi_write(ADDR_TX, 32'haa, 4'hf, 0);
        @(negedge clk);
        chk("tx_valid after push", 32'(tx_valid), 32'd1);
        chk("tx_data after push", 32'(tx_data), 32'haa);
        @(posedge clk); #1 tx_ready = 1;
        @(posedge clk); #1 tx_ready = 0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (interrupt) pulses++;
        end
        chk("tx drain interrupt pulses", 32'(pulses), 32'd1);
        axi_write(ADDR_CTRL, 32'h00, 4'hf, 0);

        for (int i = 0; i < 17; i++) axi_write(ADDR_TX, 32'(i), 4'hf, 0);
        axi_read(ADDR_STAT, d);
        chk("STAT tx_full bit", 32'(d[3]), 32'd1);
        chk("STAT tx full", d, 32'h08);
        @(posedge clk); #1 tx_ready = 1;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!tx_valid) break;
            chk("tx drain order", 32'(tx_data), 32'(got));
            got++;
        end
        @(posedge clk); #1 tx_ready = 0;
        chk("tx drained count", 32'(got), 32'd16);

        axi_write(ADDR_TX, 32'h77, 4'hf, 0);
        rx_push(8'h55, 0, 0);
        rx_push(8'h66, 0, 1);
        axi_read(ADDR_STAT, d);
        chk("STAT parity sticky", d, 32'h81);
        axi_read(ADDR_STAT, d);
        chk("STAT parity cleared", d, 32'h01);
        axi_read(ADDR_RX, d);
        chk("rx byte 0", d, 32'h55);
        axi_read(ADDR_RX, d);
        chk("rx byte 1", d, 32'h66);
        axi_read(ADDR_RX, d);
        chk("rx empty read", d, 32'h0);
        axi_read(ADDR_TX, d);
        chk("TX reads zero", d, 32'h0);
        axi_read(ADDR_CTRL, d);
        chk("CTRL reads zero", d, 32'h0);
        axi_write(ADDR_RX, 32'hff, 4'hf, 0);
        axi_write(ADDR_STAT, 32'hff, 4'hf, 0);
        axi_read(4'hB, d);
        chk("STAT via unaligned addr", d, 32'h00);

        for (int i = 0; i < 17; i++) rx_push(8'(8'h80 + i), 0, 0);
        axi_read(ADDR_STAT, d);
        chk("STAT overrun", d, 32'h23);

        @(posedge clk); #1;
        bus.s_axi_araddr = ADDR_RX; bus.s_axi_arvalid = 1;
        @(posedge clk); #1;
        rx_data = 8'hee; rx_valid = 1;
        @(negedge clk);
        chk("arready with concurrent push", 32'(bus.s_axi_arready), 32'd1);
        @(posedge clk); #1;
        rx_valid = 0; bus.s_axi_arvalid = 0; bus.s_axi_rready = 1;
        @(negedge clk);
        chk("concurrent pop rvalid", 32'(bus.s_axi_rvalid), 32'd1);
        chk("concurrent pop data", bus.s_axi_rdata, 32'h80);
        @(posedge clk); #1 bus.s_axi_rready = 0;
        axi_read(ADDR_STAT, d);
        chk("STAT no overrun on pop+push", d, 32'h03);
        for (int i = 0; i < 16; i++) begin
            axi_read(ADDR_RX, d);
            chk("rx drain", d, (i < 15) ? 32'(8'h81 + i) : 32'hee);
        end

        rx_push(8'h12, 0, 0);
        axi_write(ADDR_CTRL, 32'h03, 4'hf, 3);
        axi_read(ADDR_STAT, d);
        chk("STAT after FIFO resets", d, 32'h04);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
